// File: rtl/lcd1602_pkg.sv
// LCD1602 refresh controller shared definitions.
// Instruction bytes, controller states and DDRAM address helpers.
package lcd1602_pkg;

    localparam int unsigned NPOS = 32;

    localparam logic [7:0] FUNC_SET  = 8'h38;
    localparam logic [7:0] DISP_ON   = 8'h0C;
    localparam logic [7:0] ENTRY     = 8'h06;
    localparam logic [7:0] CLEAR     = 8'h01;
    localparam logic [7:0] SET_DDRAM = 8'h80;
    localparam logic [7:0] LINE2_OFS = 8'h40;
    localparam logic [7:0] BLANK     = 8'h20;

    typedef enum logic [2:0] {
        ST_PWR_WAIT,
        ST_INIT,
        ST_CLR_HOLD,
        ST_SCAN,
        ST_ADDR,
        ST_DATA
    } state_e;

    // Buffer position to "set DDRAM address" instruction.
    function automatic logic [7:0] ddram_addr(input logic [4:0] pos);
        return SET_DDRAM
             | (pos[4] ? LINE2_OFS : 8'h00)
             | {4'h0, pos[3:0]};
    endfunction

    // Power-up instruction sequence, in issue order.
    function automatic logic [7:0] init_cmd(input logic [1:0] idx);
        case (idx)
            2'd0:    return FUNC_SET;
            2'd1:    return DISP_ON;
            2'd2:    return ENTRY;
            default: return CLEAR;
        endcase
    endfunction

endpackage

// File: rtl/lcd1602_shadow_buf.sv
// 32-character shadow buffer with per-position dirty bits.
// Fill beats write; a write beats a clear-dirty on the same position.
module lcd1602_shadow_buf
    import lcd1602_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       wr_en_i,
    input  logic [4:0] wr_addr_i,
    input  logic [7:0] wr_char_i,
    input  logic       fill_i,
    input  logic [4:0] rd_addr_i,
    input  logic       clr_dirty_i,
    output logic [7:0] rd_char_o,
    output logic       rd_dirty_o
);

    logic [7:0]      chars_q [NPOS];
    logic [NPOS-1:0] dirty_q;
    logic [NPOS-1:0] dirty_d;

    // Character store: reset and fill both blank the screen.
    always_ff @(posedge clk_i) begin
        if (rst_i || fill_i) begin
            for (int i = 0; i < NPOS; i++) begin
                chars_q[i] <= BLANK;
            end
        end else if (wr_en_i) begin
            chars_q[wr_addr_i] <= wr_char_i;
        end
    end

    // Dirty next-state: clear first so a same-cycle write re-marks it.
    always_comb begin
        dirty_d = dirty_q;
        if (clr_dirty_i) begin
            dirty_d[rd_addr_i] = 1'b0;
        end
        if (wr_en_i) begin
            dirty_d[wr_addr_i] = 1'b1;
        end
        if (fill_i) begin
            dirty_d = '1;
        end
    end

    // Dirty register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            dirty_q <= '0;
        end else begin
            dirty_q <= dirty_d;
        end
    end

    assign rd_char_o  = chars_q[rd_addr_i];
    assign rd_dirty_o = dirty_q[rd_addr_i];

endmodule

// File: rtl/lcd1602_refresh_ctrl.sv
// LCD1602 refresh controller: power-up init, then pushes only
// changed characters to the byte-writer over call/done.
module lcd1602_refresh_ctrl
    import lcd1602_pkg::*;
#(
    parameter int unsigned INIT_WAIT = 750000,
    parameter int unsigned CLR_WAIT  = 100000
) (
    input  logic       CLOCK,
    input  logic       RST,
    input  logic       iWrEn,
    input  logic [4:0] iWrAddr,
    input  logic [7:0] iWrChar,
    input  logic       iClear,
    output logic       oReady,
    output logic       oCall,
    input  logic       iDone,
    output logic       oRS,
    output logic [7:0] oData
);

    localparam int unsigned WMAX =
        (INIT_WAIT > CLR_WAIT) ? INIT_WAIT : CLR_WAIT;
    localparam int unsigned CW = $clog2(WMAX + 1);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    idx_q, idx_d;
    logic [4:0]    ptr_q, ptr_d;
    logic [4:0]    cur_q, cur_d;
    logic          cur_vld_q, cur_vld_d;
    logic          ready_q, ready_d;
    logic          call_q, call_d;
    logic          rs_q, rs_d;
    logic [7:0]    data_q, data_d;

    logic          clr_dirty;
    logic [7:0]    rd_char;
    logic          rd_dirty;
    logic          done;
    logic          init_exp;
    logic          clr_exp;
    logic          need_addr;

    assign done      = call_q & iDone;
    assign init_exp  = (cnt_q == CW'(INIT_WAIT - 1));
    assign clr_exp   = (cnt_q == CW'(CLR_WAIT - 1));
    assign need_addr = !cur_vld_q || (cur_q != ptr_q);

    lcd1602_shadow_buf u_buf (
        .clk_i       (CLOCK),
        .rst_i       (RST),
        .wr_en_i     (iWrEn),
        .wr_addr_i   (iWrAddr),
        .wr_char_i   (iWrChar),
        .fill_i      (iClear),
        .rd_addr_i   (ptr_q),
        .clr_dirty_i (clr_dirty),
        .rd_char_o   (rd_char),
        .rd_dirty_o  (rd_dirty)
    );

    // State register.
    always_ff @(posedge CLOCK) begin
        if (RST) begin
            state_q <= ST_PWR_WAIT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: a dirty hit skips ADDR when the LCD cursor is already there.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_PWR_WAIT: if (init_exp) state_d = ST_INIT;
            ST_INIT:     if (done && idx_q == 2'd3) state_d = ST_CLR_HOLD;
            ST_CLR_HOLD: if (clr_exp) state_d = ST_SCAN;
            ST_SCAN:     if (rd_dirty) state_d = need_addr ? ST_ADDR : ST_DATA;
            ST_ADDR:     if (done) state_d = ST_DATA;
            ST_DATA:     if (done) state_d = ST_SCAN;
            default:     state_d = ST_PWR_WAIT;
        endcase
    end

    // Outputs and counters: calls launch with RS/data, drop on done.
    always_comb begin
        cnt_d     = '0;
        idx_d     = idx_q;
        ptr_d     = ptr_q;
        cur_d     = cur_q;
        cur_vld_d = cur_vld_q;
        ready_d   = ready_q;
        call_d    = call_q;
        rs_d      = rs_q;
        data_d    = data_q;
        clr_dirty = 1'b0;
        unique case (state_q)
            ST_PWR_WAIT: begin
                cnt_d = cnt_q + CW'(1);
            end
            ST_INIT: begin
                if (call_q) begin
                    if (iDone) begin
                        call_d = 1'b0;
                        idx_d  = idx_q + 2'd1;
                        if (idx_q == 2'd3) begin
                            cur_vld_d = 1'b0;
                        end
                    end
                end else begin
                    call_d = 1'b1;
                    rs_d   = 1'b0;
                    data_d = init_cmd(idx_q);
                end
            end
            ST_CLR_HOLD: begin
                cnt_d = cnt_q + CW'(1);
                if (clr_exp) begin
                    ready_d = 1'b1;
                end
            end
            ST_SCAN: begin
                if (rd_dirty) begin
                    call_d = 1'b1;
                    if (need_addr) begin
                        rs_d   = 1'b0;
                        data_d = ddram_addr(ptr_q);
                    end else begin
                        rs_d      = 1'b1;
                        data_d    = rd_char;
                        clr_dirty = 1'b1;
                    end
                end else begin
                    ptr_d = ptr_q + 5'd1;
                end
            end
            ST_ADDR: begin
                if (done) begin
                    call_d    = 1'b0;
                    cur_d     = ptr_q;
                    cur_vld_d = 1'b1;
                end
            end
            ST_DATA: begin
                if (call_q) begin
                    if (iDone) begin
                        call_d    = 1'b0;
                        cur_d     = ptr_q + 5'd1;
                        cur_vld_d = (ptr_q[3:0] != 4'hF);
                        ptr_d     = ptr_q + 5'd1;
                    end
                end else begin
                    call_d    = 1'b1;
                    rs_d      = 1'b1;
                    data_d    = rd_char;
                    clr_dirty = 1'b1;
                end
            end
            default: begin
            end
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge CLOCK) begin
        if (RST) begin
            cnt_q     <= '0;
            idx_q     <= '0;
            ptr_q     <= '0;
            cur_q     <= '0;
            cur_vld_q <= 1'b0;
            ready_q   <= 1'b0;
            call_q    <= 1'b0;
            rs_q      <= 1'b0;
            data_q    <= 8'h00;
        end else begin
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            ptr_q     <= ptr_d;
            cur_q     <= cur_d;
            cur_vld_q <= cur_vld_d;
            ready_q   <= ready_d;
            call_q    <= call_d;
            rs_q      <= rs_d;
            data_q    <= data_d;
        end
    end

    assign oReady = ready_q;
    assign oCall  = call_q;
    assign oRS    = rs_q;
    assign oData  = data_q;

endmodule

// File: tb/tb_lcd1602_refresh_ctrl.sv
// Directed bench for lcd1602_refresh_ctrl with a byte-writer model
// that answers each call with iDone three cycles after oCall rises.
module tb_lcd1602_refresh_ctrl;

    logic       CLOCK = 1'b0;
    logic       RST = 1'b1;
    logic       iWrEn = 1'b0;
    logic [4:0] iWrAddr = '0;
    logic [7:0] iWrChar = '0;
    logic       iClear = 1'b0;
    logic       iDone = 1'b0;
    logic       oReady;
    logic       oCall;
    logic       oRS;
    logic [7:0] oData;

    int total = 0;
    int bad = 0;
    int hs_err = 0;
    int wcnt = 0;

    logic [8:0] calls[$];
    logic [8:0] cur_call = '0;
    logic       prev_call = 1'b0;
    logic       prev_done = 1'b0;

    lcd1602_refresh_ctrl #(
        .INIT_WAIT (10),
        .CLR_WAIT  (5)
    ) dut (
        .CLOCK   (CLOCK),
        .RST     (RST),
        .iWrEn   (iWrEn),
        .iWrAddr (iWrAddr),
        .iWrChar (iWrChar),
        .iClear  (iClear),
        .oReady  (oReady),
        .oCall   (oCall),
        .iDone   (iDone),
        .oRS     (oRS),
        .oData   (oData)
    );

    always #5 CLOCK = ~CLOCK;

    // Byte-writer model.
    always @(posedge CLOCK) begin
        #1;
        if (RST) begin
            iDone = 1'b0;
            wcnt = 0;
        end else if (iDone) begin
            iDone = 1'b0;
        end else if (oCall) begin
            wcnt++;
            if (wcnt == 3) begin
                iDone = 1'b1;
                wcnt = 0;
            end
        end
    end

    // Call logger and handshake watcher.
    always @(negedge CLOCK) begin
        if (RST) begin
            prev_call = 1'b0;
            prev_done = 1'b0;
        end else begin
            if (prev_done && oCall) hs_err++;
            if (oCall && !prev_call) begin
                cur_call = {oRS, oData};
                calls.push_back(cur_call);
            end else if (oCall && ({oRS, oData} !== cur_call)) begin
                hs_err++;
            end
            prev_call = oCall;
            prev_done = iDone;
        end
    end

    task automatic host_write(input logic [4:0] a, input logic [7:0] c);
        iWrEn = 1'b1;
        iWrAddr = a;
        iWrChar = c;
        @(negedge CLOCK); #1;
        iWrEn = 1'b0;
    endtask

    task automatic wait_calls(input int n, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge CLOCK); #1;
            if (calls.size() >= n) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge CLOCK);
        #1;
        total++;
        if (oCall !== 1'b0) begin
            bad++; $display("FAIL reset_call got=%b want=0", oCall);
        end
        total++;
        if (oRS !== 1'b0) begin
            bad++; $display("FAIL reset_rs got=%b want=0", oRS);
        end
        total++;
        if (oData !== 8'h00) begin
            bad++; $display("FAIL reset_data got=%h want=00", oData);
        end
        total++;
        if (oReady !== 1'b0) begin
            bad++; $display("FAIL reset_ready got=%b want=0", oReady);
        end
    endtask

    task automatic test_init();
        logic [8:0] exp [7];
        bit ok;
        bit got;
        logic want;
        exp = '{9'h038, 9'h00C, 9'h006, 9'h001,
                9'h080, 9'h141, 9'h142};
        calls.delete();
        @(negedge CLOCK); #1;
        RST = 1'b0;
        host_write(5'd0, 8'h41);
        host_write(5'd1, 8'h42);
        wait_calls(4, ok);
        total++;
        if (!ok) begin
            bad++; $display("FAIL init_calls got=%0d want=4", calls.size());
        end
        if (ok) begin
            for (int i = 0; i < 4; i++) begin
                total++;
                if (calls[i] !== exp[i]) begin
                    bad++;
                    $display("FAIL init_call%0d got=%h want=%h", i, calls[i], exp[i]);
                end
            end
        end
        total++;
        if (oReady !== 1'b0) begin
            bad++; $display("FAIL ready_early got=%b want=0", oReady);
        end
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLOCK); #1;
            if (iDone) begin
                got = 1'b1;
                break;
            end
        end
        total++;
        if (!got) begin
            bad++; $display("FAIL clear_done got=0 want=1");
        end
        @(posedge CLOCK); #1;
        for (int k = 1; k <= 5; k++) begin
            @(posedge CLOCK); #1;
            want = (k == 5);
            total++;
            if (oReady !== want) begin
                bad++;
                $display("FAIL ready_edge%0d got=%b want=%b", k, oReady, want);
            end
        end
        wait_calls(7, ok);
        total++;
        if (!ok) begin
            bad++; $display("FAIL ab_calls got=%0d want=7", calls.size());
        end
        if (ok) begin
            for (int i = 4; i < 7; i++) begin
                total++;
                if (calls[i] !== exp[i]) begin
                    bad++;
                    $display("FAIL ab_call%0d got=%h want=%h", i, calls[i], exp[i]);
                end
            end
        end
    endtask

    task automatic test_line2_char();
        bit ok;
        calls.delete();
        host_write(5'd17, 8'h58);
        wait_calls(2, ok);
        total++;
        if (!ok) begin
            bad++; $display("FAIL x_calls got=%0d want=2", calls.size());
        end
        if (ok) begin
            total++;
            if (calls[0] !== 9'h0C1) begin
                bad++; $display("FAIL x_addr got=%h want=0c1", calls[0]);
            end
            total++;
            if (calls[1] !== 9'h158) begin
                bad++; $display("FAIL x_data got=%h want=158", calls[1]);
            end
        end
    endtask

    task automatic test_line_wrap();
        logic [8:0] exp [4];
        bit ok;
        exp = '{9'h08F, 9'h14D, 9'h0C0, 9'h14E};
        calls.delete();
        host_write(5'd15, 8'h4D);
        host_write(5'd16, 8'h4E);
        wait_calls(4, ok);
        total++;
        if (!ok) begin
            bad++; $display("FAIL wrap_calls got=%0d want=4", calls.size());
        end
        if (ok) begin
            for (int i = 0; i < 4; i++) begin
                total++;
                if (calls[i] !== exp[i]) begin
                    bad++;
                    $display("FAIL wrap_call%0d got=%h want=%h", i, calls[i], exp[i]);
                end
            end
        end
    endtask

    task automatic test_inflight_rewrite();
        logic [8:0] exp [4];
        bit ok;
        exp = '{9'h083, 9'h151, 9'h083, 9'h152};
        calls.delete();
        host_write(5'd3, 8'h51);
        wait_calls(2, ok);
        total++;
        if (!(oCall === 1'b1 && oRS === 1'b1)) begin
            bad++;
            $display("FAIL q_inflight got=%b%b want=11", oCall, oRS);
        end
        host_write(5'd3, 8'h52);
        wait_calls(4, ok);
        total++;
        if (!ok) begin
            bad++; $display("FAIL qr_calls got=%0d want=4", calls.size());
        end
        if (ok) begin
            for (int i = 0; i < 4; i++) begin
                total++;
                if (calls[i] !== exp[i]) begin
                    bad++;
                    $display("FAIL qr_call%0d got=%h want=%h", i, calls[i], exp[i]);
                end
            end
        end
    endtask

    task automatic test_clear_same_cycle();
        bit ok;
        int blanks;
        calls.delete();
        iClear = 1'b1;
        iWrEn = 1'b1;
        iWrAddr = 5'd5;
        iWrChar = 8'h5A;
        @(negedge CLOCK); #1;
        iClear = 1'b0;
        iWrEn = 1'b0;
        wait_calls(34, ok);
        total++;
        if (!ok) begin
            bad++; $display("FAIL clr_calls got=%0d want=34", calls.size());
        end
        if (ok) begin
            total++;
            if (calls[12] !== 9'h0C0) begin
                bad++; $display("FAIL clr_addr16 got=%h want=0c0", calls[12]);
            end
            total++;
            if (calls[29] !== 9'h080) begin
                bad++; $display("FAIL clr_addr0 got=%h want=080", calls[29]);
            end
            blanks = 0;
            foreach (calls[i]) if (calls[i] === 9'h120) blanks++;
            total++;
            if (blanks !== 32) begin
                bad++; $display("FAIL clr_blanks got=%0d want=32", blanks);
            end
        end
        repeat (100) @(negedge CLOCK);
        #1;
        total++;
        if (calls.size() !== 34) begin
            bad++; $display("FAIL clr_quiet got=%0d want=34", calls.size());
        end
    endtask

    task automatic test_reset_mid();
        bit got;
        calls.delete();
        host_write(5'd7, 8'h4B);
        got = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (oCall === 1'b1) begin
                got = 1'b1;
                break;
            end
            @(negedge CLOCK); #1;
        end
        total++;
        if (!got) begin
            bad++; $display("FAIL mid_call got=0 want=1");
        end
        RST = 1'b1;
        @(posedge CLOCK); #1;
        total++;
        if (oCall !== 1'b0) begin
            bad++; $display("FAIL mid_drop got=%b want=0", oCall);
        end
        total++;
        if (oReady !== 1'b0) begin
            bad++; $display("FAIL mid_ready got=%b want=0", oReady);
        end
        total++;
        if (oData !== 8'h00) begin
            bad++; $display("FAIL mid_data got=%h want=00", oData);
        end
        @(negedge CLOCK); #1;
        RST = 1'b0;
    endtask

    task automatic test_handshake();
        total++;
        if (hs_err !== 0) begin
            bad++; $display("FAIL handshake got=%0d want=0", hs_err);
        end
    endtask

    initial begin
        test_reset();
        test_init();
        test_line2_char();
        test_line_wrap();
        test_inflight_rewrite();
        test_clear_same_cycle();
        test_reset_mid();
        test_handshake();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
